// File: rtl/fsm_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : fsm_seq_detect_param
// Summary  : Serial trigger-pattern detector with programmable wait and check
// Revision : 1.0
// ============================================================================
module fsm_seq_detect_param #(
    parameter int unsigned          PAT_LEN     = 1,
    parameter logic [PAT_LEN-1:0]   PATTERN     = PAT_LEN'(1),
    parameter int unsigned          DELAY       = 1,
    parameter logic                 CHECK_LEVEL = 1'b1,
    parameter int unsigned          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clear,
    output logic             dout,
    output logic             busy,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_WAIT  = 3'b010,
        S_CHECK = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_match;
    logic               w_idle_adv;
    logic               w_leave_idle;
    logic               w_wait_done;

    assign w_idle_adv   = en && (state_q == S_IDLE);
    assign w_leave_idle = w_idle_adv && w_match;

    // Pattern history; cleared on leaving IDLE so sequences never overlap.
    if (PAT_LEN == 1) begin : g_single_bit
        assign w_match = (din == PATTERN[0]);
    end else begin : g_history
        localparam int HW = PAT_LEN - 1;
        localparam int FW = $clog2(PAT_LEN);
        localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

        logic [HW-1:0] hist_q, hist_d;
        logic [FW-1:0] fill_q, fill_d;

        assign w_match = (fill_q == FILL_MAX) && ({hist_q, din} == PATTERN);

        always_comb begin
            hist_d = hist_q;
            fill_d = fill_q;
            if (w_idle_adv) begin
                if (w_match) begin
                    hist_d = '0;
                    fill_d = '0;
                end else begin
                    hist_d = HW'({hist_q, din});
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + FW'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
        end
    end

    if (DELAY > 0) begin : g_delay
        logic [7:0] dcnt_q, dcnt_d;

        assign w_wait_done = (dcnt_q == 8'(DELAY - 1));

        // Counter idles at zero, so it is already loaded on WAIT entry.
        always_comb begin
            dcnt_d = dcnt_q;
            if (en) begin
                dcnt_d = (state_q == S_WAIT) ? dcnt_q + 8'd1 : 8'd0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt_q <= 8'd0;
            end else begin
                dcnt_q <= dcnt_d;
            end
        end
    end else begin : g_no_delay
        assign w_wait_done = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE:  if (w_leave_idle) state_d = (DELAY == 0) ? S_CHECK : S_WAIT;
                S_WAIT:  if (w_wait_done) state_d = S_CHECK;
                S_CHECK: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dout = 1'b0;
        busy = 1'b0;
        case (state_q)
            S_WAIT:  busy = 1'b1;
            S_CHECK: begin
                busy = 1'b1;
                dout = en && (din == CHECK_LEVEL);
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (dout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign hit_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_detect_param.sv
`default_nettype none
// Bench for fsm_seq_detect_param: five parameter sets share one stimulus stream,
// checked against a cycle-level behavioural model plus directed scenarios.
module tb_fsm_seq_detect_param;

    localparam int NC = 5;
    localparam int PL  [NC] = '{1, 3, 1, 1, 4};
    localparam int PAT [NC] = '{1, 5, 1, 1, 6};
    localparam int DLY [NC] = '{1, 2, 0, 1, 3};
    localparam int CL  [NC] = '{1, 1, 1, 1, 0};
    localparam int CW  [NC] = '{8, 8, 8, 2, 3};

    logic clk, rst_n, din, en, clear;
    logic [NC-1:0] dout_v, busy_v;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic [2:0] cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_seen   [NC];
    int unsigned m_recent [NC];
    int          m_cd     [NC];   // -1 idle, 0 checking, >0 wait cycles left
    int          m_hits   [NC];

    fsm_seq_detect_param #(.PAT_LEN(1), .PATTERN(1'b1), .DELAY(1), .CHECK_LEVEL(1'b1), .CNT_W(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear),
        .dout(dout_v[0]), .busy(busy_v[0]), .hit_count(cnt0));
    fsm_seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .DELAY(2), .CHECK_LEVEL(1'b1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear),
        .dout(dout_v[1]), .busy(busy_v[1]), .hit_count(cnt1));
    fsm_seq_detect_param #(.PAT_LEN(1), .PATTERN(1'b1), .DELAY(0), .CHECK_LEVEL(1'b1), .CNT_W(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear),
        .dout(dout_v[2]), .busy(busy_v[2]), .hit_count(cnt2));
    fsm_seq_detect_param #(.PAT_LEN(1), .PATTERN(1'b1), .DELAY(1), .CHECK_LEVEL(1'b1), .CNT_W(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear),
        .dout(dout_v[3]), .busy(busy_v[3]), .hit_count(cnt3));
    fsm_seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b0110), .DELAY(3), .CHECK_LEVEL(1'b0), .CNT_W(3)) u_d4 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear),
        .dout(dout_v[4]), .busy(busy_v[4]), .hit_count(cnt4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int obs_cnt(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            2:       return int'(cnt2);
            3:       return int'(cnt3);
            default: return int'(cnt4);
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            m_seen[k] = 0; m_recent[k] = 0; m_cd[k] = -1; m_hits[k] = 0;
        end
    endfunction

    function automatic bit exp_busy(input int k);
        return m_cd[k] >= 0;
    endfunction

    function automatic bit exp_dout(input int k);
        return (m_cd[k] == 0) && (en === 1'b1) && (int'(din) == CL[k]);
    endfunction

    // One clock edge of every configuration, from the current inputs.
    function automatic void model_tick();
        for (int k = 0; k < NC; k++) begin
            bit hit;
            int unsigned mask;
            hit  = 1'b0;
            mask = (32'd1 << PL[k]) - 32'd1;
            if (en) begin
                if (m_cd[k] < 0) begin
                    m_seen[k]++;
                    m_recent[k] = (m_recent[k] << 1) | {31'd0, din};
                    if (m_seen[k] >= PL[k] && (m_recent[k] & mask) == PAT[k]) begin
                        m_cd[k] = DLY[k]; m_seen[k] = 0; m_recent[k] = 0;
                    end
                end else if (m_cd[k] == 0) begin
                    hit = (int'(din) == CL[k]);
                    m_cd[k] = -1;
                end else begin
                    m_cd[k]--;
                end
            end
            if (clear) m_hits[k] = 0;
            else if (hit && m_hits[k] < (1 << CW[k]) - 1) m_hits[k]++;
        end
    endfunction

    task automatic drive(input logic d, input logic e, input logic c);
        din = d; en = e; clear = c;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_tick();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; din = 1'b0; en = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic rbit(input int v);
        return (v == 2) ? 1'($urandom % 2) : 1'(v);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b1; en = 1'b1; clear = 1'b0;
        model_reset();
        #3;
        for (int k = 0; k < NC; k++) begin
            n_cmp++; if (busy_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy_v[k]); end
            n_cmp++; if (dout_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_dout[%0d] got=%b exp=0", k, dout_v[k]); end
            n_cmp++; if (obs_cnt(k) !== 0) begin n_bad++; $display("FAIL reset_cnt[%0d] got=%0d exp=0", k, obs_cnt(k)); end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int d_pat [8] = '{1, 2, 1, 0, 1, 2, 0, 0};
        bit b_exp [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        bit o_exp [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(rbit(d_pat[i]), 1'b1, 1'b0);
            n_cmp++; if (busy_v[0] !== b_exp[i]) begin n_bad++; $display("FAIL def_busy c%0d got=%b exp=%b", i, busy_v[0], b_exp[i]); end
            n_cmp++; if (dout_v[0] !== o_exp[i]) begin n_bad++; $display("FAIL def_dout c%0d got=%b exp=%b", i, dout_v[0], o_exp[i]); end
            tick();
        end
        n_cmp++; if (cnt0 !== 8'd1) begin n_bad++; $display("FAIL def_cnt got=%0d exp=1", cnt0); end
    endtask

    task automatic test_pattern3();
        int d_pat [14] = '{1, 0, 1, 2, 2, 1, 1, 1, 0, 1, 2, 2, 0, 0};
        bit b_exp [14] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        bit o_exp [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(rbit(d_pat[i]), 1'b1, 1'b0);
            n_cmp++; if (busy_v[1] !== b_exp[i]) begin n_bad++; $display("FAIL p3_busy c%0d got=%b exp=%b", i, busy_v[1], b_exp[i]); end
            n_cmp++; if (dout_v[1] !== o_exp[i]) begin n_bad++; $display("FAIL p3_dout c%0d got=%b exp=%b", i, dout_v[1], o_exp[i]); end
            tick();
        end
        n_cmp++; if (cnt1 !== 8'd1) begin n_bad++; $display("FAIL p3_cnt got=%0d exp=1", cnt1); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(logic'(i == 1), 1'b1, 1'b0);
            n_cmp++; if (busy_v[1] !== 1'b0) begin n_bad++; $display("FAIL p3_nofill c%0d got=%b exp=0", i, busy_v[1]); end
            tick();
        end
    endtask

    task automatic test_delay0();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            n_cmp++; if (busy_v[2] !== 1'(i % 2)) begin n_bad++; $display("FAIL d0_busy c%0d got=%b exp=%b", i, busy_v[2], 1'(i % 2)); end
            n_cmp++; if (dout_v[2] !== 1'(i % 2)) begin n_bad++; $display("FAIL d0_dout c%0d got=%b exp=%b", i, dout_v[2], 1'(i % 2)); end
            tick();
        end
        n_cmp++; if (cnt2 !== 8'd4) begin n_bad++; $display("FAIL d0_cnt got=%0d exp=4", cnt2); end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        repeat (15) begin drive(1'b1, 1'b1, 1'b0); tick(); end
        n_cmp++; if (cnt3 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt3 got=%0d exp=3", cnt3); end
        n_cmp++; if (cnt0 !== 8'd5) begin n_bad++; $display("FAIL sat_cnt0 got=%0d exp=5", cnt0); end
        drive(1'b1, 1'b1, 1'b0); tick();
        drive(rbit(2), 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1);
        n_cmp++; if (dout_v[3] !== 1'b1) begin n_bad++; $display("FAIL clr_hit_dout got=%b exp=1", dout_v[3]); end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++; if (cnt3 !== 2'd0) begin n_bad++; $display("FAIL clr_cnt3 got=%0d exp=0", cnt3); end
        n_cmp++; if (cnt0 !== 8'd0) begin n_bad++; $display("FAIL clr_cnt0 got=%0d exp=0", cnt0); end
        tick();
    endtask

    task automatic test_en_freeze();
        int d_pat [7] = '{1, 1, 1, 1, 2, 1, 0};
        bit e_pat [7] = '{1, 0, 0, 0, 1, 1, 1};
        bit b_exp [7] = '{0, 1, 1, 1, 1, 1, 0};
        bit o_exp [7] = '{0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(rbit(d_pat[i]), e_pat[i], 1'b0);
            n_cmp++; if (busy_v[0] !== b_exp[i]) begin n_bad++; $display("FAIL en_busy c%0d got=%b exp=%b", i, busy_v[0], b_exp[i]); end
            n_cmp++; if (dout_v[0] !== o_exp[i]) begin n_bad++; $display("FAIL en_dout c%0d got=%b exp=%b", i, dout_v[0], o_exp[i]); end
            tick();
        end
        n_cmp++; if (cnt0 !== 8'd1) begin n_bad++; $display("FAIL en_cnt got=%0d exp=1", cnt0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b1, 1'b0); tick();
        drive(rbit(2), 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0);
        n_cmp++; if (dout_v[0] !== 1'b1) begin n_bad++; $display("FAIL ar_pre_dout got=%b exp=1", dout_v[0]); end
        #1 rst_n = 1'b0; din = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (dout_v[0] !== 1'b0) begin n_bad++; $display("FAIL ar_dout got=%b exp=0", dout_v[0]); end
        n_cmp++; if (busy_v !== '0) begin n_bad++; $display("FAIL ar_busy got=%b exp=0", busy_v); end
        n_cmp++; if (cnt0 !== 8'd0) begin n_bad++; $display("FAIL ar_cnt got=%0d exp=0", cnt0); end
        #1 rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL ar_post_busy got=%b exp=0", busy_v[0]); end
        tick();
        drive(1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL ar_retrig_busy got=%b exp=1", busy_v[0]); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic e;
            e = logic'(($urandom % 10) != 0);
            drive(1'($urandom % 2), e, e && (($urandom % 40) == 0));
            for (int k = 0; k < NC; k++) begin
                n_cmp++; if (busy_v[k] !== exp_busy(k)) begin n_bad++; $display("FAIL rnd_busy[%0d] c%0d got=%b exp=%b", k, i, busy_v[k], exp_busy(k)); end
                n_cmp++; if (dout_v[k] !== exp_dout(k)) begin n_bad++; $display("FAIL rnd_dout[%0d] c%0d got=%b exp=%b", k, i, dout_v[k], exp_dout(k)); end
                n_cmp++; if (obs_cnt(k) !== m_hits[k]) begin n_bad++; $display("FAIL rnd_cnt[%0d] c%0d got=%0d exp=%0d", k, i, obs_cnt(k), m_hits[k]); end
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_defaults();
        test_pattern3();
        test_delay0();
        test_saturate_clear();
        test_en_freeze();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
